// File: rtl/parity_stream_checker.sv
// parity_stream_checker: receives data words with a parity bit over a
// valid/ready stream, flags mismatching words, forwards each word through a
// single output register, and keeps error statistics. It can optionally stop
// taking input after a bad word until software pulses clr_err.
module parity_stream_checker #(
  parameter int DATA_W      = 64,
  parameter int CNT_W       = 16,
  parameter int PARITY_ODD  = 0,
  parameter int HALT_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  input  logic              clr_err,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [CNT_W-1:0]  word_count,
  output logic              halted
);

  localparam logic             ODD     = (PARITY_ODD != 0);
  localparam logic             HALT_EN = (HALT_ON_ERR != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  // One forwarded word plus its mismatch flag
  typedef struct packed {
    logic              vld;
    logic [DATA_W-1:0] data;
    logic              err;
  } slot_t;

  state_t             state_q;
  logic               halted_q;
  slot_t              slot_q, slot_d;
  logic               sticky_q, sticky_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   wc_q, wc_d;

  logic accept, xfer, mism, bad_acc;

  // No skid buffer: a stalled output register blocks intake in the same cycle
  assign in_ready = (state_q == RUN) && (!slot_q.vld || out_ready);
  assign accept   = in_valid && in_ready;
  assign xfer     = slot_q.vld && out_ready;
  assign mism     = ((^in_data) ^ ODD) != in_par;
  assign bad_acc  = accept && mism;

  // Output register: load on accept, empty on drain, otherwise hold stable
  always_comb begin
    slot_d = slot_q;
    if (accept) begin
      slot_d.vld  = 1'b1;
      slot_d.data = in_data;
      slot_d.err  = mism;
    end else if (xfer) begin
      slot_d.vld = 1'b0;
    end
  end

  // Accepted-word counter, wraps modulo 2^CNT_W and ignores clr_err
  assign wc_d = accept ? wc_q + CNT_ONE : wc_q;

  // Statistics: a clear lands first so a same-cycle bad word starts a fresh record
  always_comb begin
    sticky_d = clr_err ? 1'b0 : sticky_q;
    cnt_d    = clr_err ? '0   : cnt_q;
    idx_d    = clr_err ? '0   : idx_q;
    if (bad_acc) begin
      if (cnt_d == '0) idx_d = wc_q;
      sticky_d = 1'b1;
      if (cnt_d != CNT_MAX) cnt_d = cnt_d + CNT_ONE;
    end
  end

  // Datapath and statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      wc_q     <= '0;
    end else begin
      slot_q   <= slot_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wc_q     <= wc_d;
    end
  end

  // RUN/HALT control; the bad word that triggers HALT is still forwarded
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (bad_acc && HALT_EN) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          if (clr_err) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid     = slot_q.vld;
  assign out_data      = slot_q.data;
  assign out_err       = slot_q.err;
  assign err_sticky    = sticky_q;
  assign err_count     = cnt_q;
  assign first_err_idx = idx_q;
  assign word_count    = wc_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_parity_stream_checker.sv
// Bench for parity_stream_checker: two instances (HALT_ON_ERR=0 and =1) share
// one stimulus stream; a behavioural model of each is checked every cycle and
// directed steps pin literal values.
module tb_parity_stream_checker;

  localparam int CMAX = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_par, out_ready, clr_err;
  logic [63:0] in_data;

  logic        rdy[2], ov[2], oe[2], sticky[2], halted[2];
  logic [63:0] od[2];
  logic [15:0] cnt[2], idx[2], wc[2];

  parity_stream_checker #(.HALT_ON_ERR(0)) u_run (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_data(in_data), .in_par(in_par), .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_err(oe[0]), .clr_err(clr_err), .err_sticky(sticky[0]),
    .err_count(cnt[0]), .first_err_idx(idx[0]), .word_count(wc[0]), .halted(halted[0])
  );

  parity_stream_checker #(.HALT_ON_ERR(1)) u_halt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_data(in_data), .in_par(in_par), .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_err(oe[1]), .clr_err(clr_err), .err_sticky(sticky[1]),
    .err_count(cnt[1]), .first_err_idx(idx[1]), .word_count(wc[1]), .halted(halted[1])
  );

  typedef struct {
    bit          ov;
    logic [63:0] od;
    bit          oe;
    bit          sticky;
    int          cnt;
    int          idx;
    int          wc;
    bit          halt;
  } model_t;

  model_t m[2];
  int     n_chk = 0, n_pass = 0, n_fail = 0;
  bit     started = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      if (n_fail < 40) $display("FAIL %s: got %h want %h", nm, act, exp);
      n_fail++;
    end
  endtask

  // Even parity: a word is bad when data ones plus parity bit is odd
  function automatic bit is_bad(logic [63:0] d, logic p);
    return (($countones(d) + int'(p)) % 2) != 0;
  endfunction

  function automatic bit exp_rdy(model_t s);
    return !s.halt && (!s.ov || out_ready);
  endfunction

  function automatic model_t step(model_t s, bit halt_en);
    model_t n;
    bit acc, bad;
    n = s;
    if (rst) begin
      n.ov = 0; n.od = '0; n.oe = 0; n.sticky = 0;
      n.cnt = 0; n.idx = 0; n.wc = 0; n.halt = 0;
      return n;
    end
    acc = in_valid && exp_rdy(s);
    bad = is_bad(in_data, in_par);
    if (clr_err) begin
      n.sticky = 0; n.cnt = 0; n.idx = 0; n.halt = 0;
    end
    if (acc && bad) begin
      if (n.cnt == 0) n.idx = s.wc;
      n.sticky = 1;
      if (n.cnt < CMAX) n.cnt = n.cnt + 1;
      if (halt_en) n.halt = 1;
    end
    if (acc) begin
      n.ov = 1; n.od = in_data; n.oe = bad; n.wc = (s.wc + 1) % 65536;
    end else if (s.ov && out_ready) begin
      n.ov = 0;
    end
    return n;
  endfunction

  always @(posedge clk)
    for (int i = 0; i < 2; i++) m[i] <= step(m[i], i == 1);

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d_in_ready", i), 64'(rdy[i]), 64'(exp_rdy(m[i])));
        chk($sformatf("m%0d_out_valid", i), 64'(ov[i]), 64'(m[i].ov));
        if (m[i].ov) begin
          chk($sformatf("m%0d_out_data", i), od[i], m[i].od);
          chk($sformatf("m%0d_out_err", i), 64'(oe[i]), 64'(m[i].oe));
        end
        chk($sformatf("m%0d_sticky", i), 64'(sticky[i]), 64'(m[i].sticky));
        chk($sformatf("m%0d_err_count", i), 64'(cnt[i]), 64'(m[i].cnt));
        chk($sformatf("m%0d_first_idx", i), 64'(idx[i]), 64'(m[i].idx));
        chk($sformatf("m%0d_word_count", i), 64'(wc[i]), 64'(m[i].wc));
        chk($sformatf("m%0d_halted", i), 64'(halted[i]), 64'(m[i].halt));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [63:0] d, input bit p);
    in_valid = v; in_data = d; in_par = p;
  endtask

  logic [63:0] t1_w[4];
  bit          t1_p[4];
  logic [63:0] dv;
  bit          pv;

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_par = 0; out_ready = 1; clr_err = 0;
    tick();
    started = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", 64'(ov[i]), 64'd0);
      chk("rst_word_count", 64'(wc[i]), 64'd0);
      chk("rst_err_count", 64'(cnt[i]), 64'd0);
      chk("rst_halted", 64'(halted[i]), 64'd0);
    end
    rst = 0;

    // Four good words, full throughput
    t1_w[0] = 64'h0; t1_w[1] = 64'h1; t1_w[2] = 64'h3; t1_w[3] = {64{1'b1}};
    t1_p[0] = 0;     t1_p[1] = 1;     t1_p[2] = 0;     t1_p[3] = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1, t1_w[k], t1_p[k]);
      tick();
      chk("t1_out_valid", 64'(ov[0]), 64'd1);
      chk("t1_out_data", od[0], t1_w[k]);
      chk("t1_out_err", 64'(oe[0]), 64'd0);
    end
    drive(0, '0, 0);
    tick();
    chk("t1_word_count", 64'(wc[0]), 64'd4);
    chk("t1_err_count", 64'(cnt[0]), 64'd0);

    // Bad word at index 2; halting instance stops after it
    rst = 1; tick(); rst = 0;
    drive(1, 64'h1, 1); tick();
    drive(1, 64'h3, 0); tick();
    drive(1, 64'h20, 0); tick();
    chk("t2_out_err", 64'(oe[0]), 64'd1);
    chk("t2_out_data", od[0], 64'h20);
    chk("t2_sticky", 64'(sticky[0]), 64'd1);
    chk("t2_err_count", 64'(cnt[0]), 64'd1);
    chk("t2_first_idx", 64'(idx[0]), 64'd2);
    chk("t2_run_halted", 64'(halted[0]), 64'd0);
    chk("t2_halt_halted", 64'(halted[1]), 64'd1);
    chk("t2_halt_out_data", od[1], 64'h20);
    chk("t2_halt_out_err", 64'(oe[1]), 64'd1);
    drive(1, 64'h5, 0);
    #1;
    chk("t2_halt_in_ready", 64'(rdy[1]), 64'd0);
    chk("t2_run_in_ready", 64'(rdy[0]), 64'd1);
    tick();
    chk("t2_run_next", od[0], 64'h5);
    chk("t2_run_wc", 64'(wc[0]), 64'd4);
    chk("t2_halt_wc", 64'(wc[1]), 64'd3);
    drive(0, '0, 0);
    clr_err = 1; tick(); clr_err = 0;
    chk("t2_clr_halted", 64'(halted[1]), 64'd0);
    chk("t2_clr_count", 64'(cnt[1]), 64'd0);
    chk("t2_clr_sticky", 64'(sticky[0]), 64'd0);
    chk("t2_clr_idx", 64'(idx[0]), 64'd0);
    chk("t2_clr_keeps_wc", 64'(wc[0]), 64'd4);

    // Backpressure: out_ready low for three cycles with a waiting source
    out_ready = 0;
    drive(1, 64'hAA, 0); tick();
    chk("t3_first", od[0], 64'hAA);
    drive(1, 64'hBB, 0);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t3_stall_in_ready", 64'(rdy[0]), 64'd0);
      tick();
      chk("t3_stall_hold", od[0], 64'hAA);
    end
    out_ready = 1;
    tick();
    chk("t3_release", od[0], 64'hBB);
    drive(0, '0, 0); tick();
    chk("t3_drained", 64'(ov[0]), 64'd0);
    chk("t3_wc_once", 64'(wc[0]), 64'd6);

    // clr_err together with a bad word at index 7
    rst = 1; tick(); rst = 0;
    for (int k = 0; k < 7; k++) begin
      dv = 64'(k);
      pv = ^dv;
      if (k == 3) pv = ~pv;
      drive(1, dv, pv);
      tick();
    end
    chk("t4_pre_count", 64'(cnt[0]), 64'd1);
    chk("t4_pre_idx", 64'(idx[0]), 64'd3);
    drive(1, 64'h7, 0);
    clr_err = 1; tick(); clr_err = 0;
    drive(0, '0, 0);
    chk("t4_count", 64'(cnt[0]), 64'd1);
    chk("t4_sticky", 64'(sticky[0]), 64'd1);
    chk("t4_idx", 64'(idx[0]), 64'd7);
    chk("t4_halt_released", 64'(halted[1]), 64'd0);

    // Reset in the middle of a stream
    drive(1, 64'h9, 0); tick();
    rst = 1; tick(); rst = 0;
    drive(0, '0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("t5_out_valid", 64'(ov[i]), 64'd0);
      chk("t5_out_data", od[i], 64'd0);
      chk("t5_out_err", 64'(oe[i]), 64'd0);
      chk("t5_sticky", 64'(sticky[i]), 64'd0);
      chk("t5_count", 64'(cnt[i]), 64'd0);
      chk("t5_idx", 64'(idx[i]), 64'd0);
      chk("t5_wc", 64'(wc[i]), 64'd0);
      chk("t5_halted", 64'(halted[i]), 64'd0);
    end

    // Random traffic against the model
    repeat (3000) begin
      rst       = ($urandom % 400) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_data   = {$urandom, $urandom};
      in_par    = (^in_data) ^ (($urandom % 4) == 0);
      out_ready = ($urandom % 10) < 7;
      clr_err   = ($urandom % 60) == 0;
      tick();
    end
    rst = 0; clr_err = 0; out_ready = 1; drive(0, '0, 0);

    // Saturation of err_count and wrap of word_count
    rst = 1; tick(); rst = 0;
    drive(1, 64'h1, 0);
    repeat (CMAX) tick();
    chk("t6_count_full", 64'(cnt[0]), 64'hFFFF);
    chk("t6_wc_full", 64'(wc[0]), 64'hFFFF);
    chk("t6_idx", 64'(idx[0]), 64'd0);
    tick();
    chk("t6_count_sat", 64'(cnt[0]), 64'hFFFF);
    chk("t6_wc_wrap", 64'(wc[0]), 64'd0);
    drive(1, 64'h0, 0); tick();
    chk("t6_wc_after", 64'(wc[0]), 64'd1);
    chk("t6_good_err", 64'(oe[0]), 64'd0);
    drive(0, '0, 0); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
